// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared types and defaults for the SPI/I2C register bank arbiter
package reg_bank_pkg;

  localparam int ADDR_WIDTH_DEF = 3;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int CNT_WIDTH_DEF  = 8;

  typedef enum logic {
    REQ_SPI = 1'b0,
    REQ_I2C = 1'b1
  } req_id_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_e;

  // Lock mode narrows eligibility to the selected front-end; bit 0 = SPI, bit 1 = I2C.
  function automatic logic [1:0] eligible_mask(input logic lock_en, input logic lock_sel,
                                               input logic spi_req, input logic i2c_req);
    logic [1:0] m;
    m[0] = spi_req & (~lock_en | ~lock_sel);
    m[1] = i2c_req & (~lock_en |  lock_sel);
    return m;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational 2-way round-robin pick between SPI and I2C
module rr_arb2
  import reg_bank_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_e    last_grant,
  output logic       grant_valid,
  output req_id_e    grant_id,
  output logic       conflict
);

  always_comb begin
    grant_valid = |req;
    conflict    = &req;
    grant_id    = REQ_SPI;
    if (conflict) begin
      // On a tie the requester that did not win the previous tie goes first.
      if (last_grant == REQ_SPI) begin
        grant_id = REQ_I2C;
      end
    end else if (req[1]) begin
      grant_id = REQ_I2C;
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// rtl/reg_bank_arbiter.sv - shares one register bank between SPI and I2C front-ends
module reg_bank_arbiter
  import reg_bank_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  lock_en_i,
  input  logic                  lock_sel_i,
  input  logic                  spi_req_i,
  input  logic                  spi_we_i,
  input  logic [ADDR_WIDTH-1:0] spi_addr_i,
  input  logic [DATA_WIDTH-1:0] spi_wdata_i,
  output logic [DATA_WIDTH-1:0] spi_rdata_o,
  output logic                  spi_ack_o,
  input  logic                  i2c_req_i,
  input  logic                  i2c_we_i,
  input  logic [ADDR_WIDTH-1:0] i2c_addr_i,
  input  logic [DATA_WIDTH-1:0] i2c_wdata_i,
  output logic [DATA_WIDTH-1:0] i2c_rdata_o,
  output logic                  i2c_ack_o,
  output logic [ADDR_WIDTH-1:0] bank_addr_o,
  output logic [DATA_WIDTH-1:0] bank_wdata_o,
  output logic                  bank_we_o,
  input  logic [DATA_WIDTH-1:0] bank_rdata_i,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  conflict_cnt_o
);

  state_e                state_q, state_d;
  req_id_e               grant_q;
  req_id_e               last_grant_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] spi_rdata_q;
  logic [DATA_WIDTH-1:0] i2c_rdata_q;
  logic [CNT_WIDTH-1:0]  conflict_cnt_q;

  logic [1:0] eligible;
  logic       arb_valid;
  req_id_e    arb_id;
  logic       arb_conflict;
  logic       take_grant;

  assign eligible = eligible_mask(lock_en_i, lock_sel_i, spi_req_i, i2c_req_i);

  rr_arb2 u_rr_arb2 (
    .req         (eligible),
    .last_grant  (last_grant_q),
    .grant_valid (arb_valid),
    .grant_id    (arb_id),
    .conflict    (arb_conflict)
  );

  always_comb begin
    state_d    = state_q;
    take_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (ena && arb_valid) begin
          take_grant = 1'b1;
          state_d    = ACCESS;
        end
      end
      ACCESS:  state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request fields are frozen at grant so later input changes cannot disturb the access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q      <= REQ_SPI;
      last_grant_q <= REQ_I2C;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else if (take_grant) begin
      grant_q <= arb_id;
      if (arb_conflict) begin
        last_grant_q <= arb_id;
      end
      if (arb_id == REQ_SPI) begin
        we_q    <= spi_we_i;
        addr_q  <= spi_addr_i;
        wdata_q <= spi_wdata_i;
      end else begin
        we_q    <= i2c_we_i;
        addr_q  <= i2c_addr_i;
        wdata_q <= i2c_wdata_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_rdata_q <= '0;
      i2c_rdata_q <= '0;
    end else if (state_q == ACCESS && !we_q) begin
      if (grant_q == REQ_SPI) begin
        spi_rdata_q <= bank_rdata_i;
      end else begin
        i2c_rdata_q <= bank_rdata_i;
      end
    end
  end

  // Only a real two-way tie while unlocked counts; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt_q <= '0;
    end else if (state_q == IDLE && ena && !lock_en_i && arb_conflict
                 && conflict_cnt_q != {CNT_WIDTH{1'b1}}) begin
      conflict_cnt_q <= conflict_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign bank_addr_o    = addr_q;
  assign bank_wdata_o   = wdata_q;
  assign bank_we_o      = (state_q == ACCESS) && we_q;
  assign spi_ack_o      = (state_q == ACK) && (grant_q == REQ_SPI);
  assign i2c_ack_o      = (state_q == ACK) && (grant_q == REQ_I2C);
  assign spi_rdata_o    = spi_rdata_q;
  assign i2c_rdata_o    = i2c_rdata_q;
  assign busy_o         = (state_q != IDLE);
  assign conflict_cnt_o = conflict_cnt_q;

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
Shares the single register bank between the SPI and I2C peripheral front-ends so both can access it without a static protocol select.
Each requester runs a req/ack handshake. The block applies 2-way round-robin arbitration, sequences one bank access per grant and returns read data.
It sits between the two serial front-ends and the register bank inside sunrise_digital_top.
A lock mode keeps the legacy fixed-select behaviour.

Parameters:
ADDR_WIDTH, 3, register bank address width (8 registers)
DATA_WIDTH, 8, register data width
CNT_WIDTH, 8, width of the saturating conflict counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  arbiter enable; 0 blocks new grants
lock_en_i  in  1  1 = only the requester chosen by lock_sel_i is served
lock_sel_i  in  1  0 = SPI, 1 = I2C (used when lock_en_i=1)
spi_req_i  in  1  SPI access request, held until spi_ack_o
spi_we_i  in  1  SPI write (1) / read (0)
spi_addr_i  in  ADDR_WIDTH  SPI register address
spi_wdata_i  in  DATA_WIDTH  SPI write data
spi_rdata_o  out  DATA_WIDTH  SPI read data, valid with spi_ack_o and held until next SPI ack
spi_ack_o  out  1  one-cycle completion pulse
i2c_req_i, i2c_we_i, i2c_addr_i, i2c_wdata_i, i2c_rdata_o, i2c_ack_o  same as SPI set, for I2C
bank_addr_o  out  ADDR_WIDTH  bank address
bank_wdata_o  out  DATA_WIDTH  bank write data
bank_we_o  out  1  one-cycle write strobe
bank_rdata_i  in  DATA_WIDTH  combinational bank read data for bank_addr_o
busy_o  out  1  high when the FSM is not IDLE
conflict_cnt_o  out  CNT_WIDTH  saturating count of arbitration cycles where both requested

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; all acks, bank_we_o and busy_o = 0; rdata, bank_addr_o, bank_wdata_o and conflict_cnt_o = 0; last_grant = I2C, so SPI wins the first tie.
- FSM IDLE:
  - If ena=1 and an eligible req is high, latch the winner's we/addr/wdata and the grant id, then go to ACCESS.
  - Eligible: any requester when lock_en_i=0; only the lock_sel_i requester when lock_en_i=1.
  - Tie: grant the requester that is not last_grant, then update last_grant.
  - A tie in IDLE with ena=1 and lock_en_i=0 increments conflict_cnt_o. It saturates at all-ones with no wrap.
- FSM ACCESS (1 cycle):
  - Drive bank_addr_o and bank_wdata_o from the latched values.
  - bank_we_o = latched we.
  - Capture bank_rdata_i into the granted requester's rdata register (captured on reads only; writes leave rdata unchanged).
  - Go to ACK.
- FSM ACK (1 cycle): pulse the granted requester's ack, then go to IDLE.
- Latency: req high at cycle N in IDLE → bank_we_o/read at N+1 → ack at N+2. Minimum spacing between grants is 3 cycles.
- Handshake rules:
  - A req still high in the cycle after ack is treated as a new request.
  - Requesters must drop req in the ack cycle's following edge.
  - A req dropped before grant is ignored.
  - A req dropped after grant does not cancel the access: the write commits and ack still pulses.
- Grant inputs: request fields are sampled only at grant. Later changes do not affect the in-flight access.
- ena=0: an in-flight access completes normally; IDLE issues no new grants.
- lock_en_i or lock_sel_i change: takes effect at the next IDLE arbitration. The in-flight access is unaffected.
- Ungranted requester: never acked while locked out, and its rdata is held.
- Reset mid-operation: immediate return to reset values. No ack is issued and no write occurs after reset assertion.
- Invariant: bank_we_o is high only in ACCESS, and never for two consecutive cycles.

Decomposition:
- reg_bank_pkg holds:
  - ADDR_WIDTH/DATA_WIDTH defaults
  - requester id enum (REQ_SPI=0, REQ_I2C=1)
  - FSM state enum (IDLE, ACCESS, ACK)
- Sub-module rr_arb2: combinational 2-way round-robin pick from the eligible request vector and last_grant. Outputs the grant id and a conflict flag.

Test Plan:
1. SPI write addr 3 data 0xA5, then SPI read addr 3 → bank_we_o pulses at N+1 with addr 3/0xA5; spi_ack_o at N+2; read gives spi_rdata_o=0xA5; i2c_ack_o stays 0.
2. SPI and I2C request writes in the same cycle (addr 1 0x11 / addr 2 0x22) → SPI granted first, I2C next; acks 3 cycles apart; conflict_cnt_o=1; the next tie goes to I2C first.
3. lock_en_i=1, lock_sel_i=1; SPI and I2C both request → only I2C acked; SPI req held 20 cycles gets no ack; lock_en_i=0 → SPI acked within 3 cycles.
4. Assert rst_n low during ACCESS of an I2C write → no ack; outputs at reset values immediately; the bank register keeps its old value if reset arrives before the clk edge.
5. ena=0 with SPI req high → no grant, busy_o=0; ena=1 → ack 2 cycles later.
6. Force 300 tie cycles → conflict_cnt_o saturates at 0xFF.
